// File: rtl/spi_master_if.sv
// Host-side handshake plus SPI pins of the mode-0 SPI master.
// The master modport is the view taken by spi_master itself.
// The slave modport is the view of whatever drives the master:
// a host, a bench or an FPGA top.
interface spi_master_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              ready;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic              busy;
    logic              sclk;
    logic              ss;
    logic              mosi;
    logic              miso;

    modport master (
        input  start, data_in, miso,
        output ready, data_out, done, busy, sclk, ss, mosi
    );

    modport slave (
        output start, data_in, miso,
        input  ready, data_out, done, busy, sclk, ss, mosi
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), MSB first, fixed DATA_W-bit frames.
// Every frame is a sequence of phases, each lasting CLK_HALF clk cycles:
//   SETUP, then (HIGH, LOW) repeated DATA_W-1 times, then HIGH, HOLD, GAP.
// All pin outputs come straight from flops, so sclk, ss and mosi are glitch-free.
module spi_master #(
    parameter int DATA_W   = 32,
    parameter int CLK_HALF = 8
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    localparam int DIV_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              sclk_q, sclk_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              phase_end;

    // Next-state logic: phase divider, bit counter, shift registers and pins.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        sclk_d     = sclk_q;
        ss_d       = ss_q;
        mosi_d     = mosi_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        phase_end = (div_q == DIV_LAST);
        // The divider free-runs inside a frame and wraps at every phase boundary.
        div_d = phase_end ? '0 : div_q + DIV_W'(1);

        case (state_q)
            IDLE: begin
                div_d = '0;
                if (bus.start && ready_q) begin
                    // Capture the word now; later data_in changes cannot reach this frame.
                    tx_d    = bus.data_in;
                    rx_d    = '0;
                    bit_d   = '0;
                    mosi_d  = bus.data_in[DATA_W-1];
                    ss_d    = 1'b0;
                    ready_d = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    // Sample miso on the falling edge, after a full high phase.
                    sclk_d = 1'b0;
                    rx_d   = {rx_q[DATA_W-2:0], bus.miso};
                    if (bit_q != BIT_LAST) begin
                        // The next bit goes out at the start of the low phase, so mosi
                        // is stable for CLK_HALF cycles before the next rising edge.
                        bit_d   = bit_q + BIT_W'(1);
                        tx_d    = {tx_q[DATA_W-2:0], 1'b0};
                        mosi_d  = tx_q[DATA_W-2];
                        state_d = LOW;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            LOW: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    ss_d       = 1'b1;
                    data_out_d = rx_q;
                    done_d     = 1'b1;
                    state_d    = GAP;
                end
            end
            GAP: begin
                // ready stays low here so ss is high for at least one phase between frames.
                if (phase_end) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
                sclk_d  = 1'b0;
                ss_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            sclk_q     <= 1'b0;
            ss_q       <= 1'b1;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            sclk_q     <= sclk_d;
            ss_q       <= ss_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign bus.sclk     = sclk_q;
    assign bus.ss       = ss_q;
    assign bus.mosi     = mosi_q;
    assign bus.ready    = ready_q;
    assign bus.busy     = ~ready_q;
    assign bus.done     = done_q;
    assign bus.data_out = data_out_q;
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master (CPOL=0, CPHA=0), MSB first, fixed DATA_W-bit frames.
- Generates sclk/ss/mosi for spi_slave and samples its miso; it is the upstream stage driving the slave's serial port.
- Replaces the behavioural pin driver in bench and FPGA bring-up.
- Host side is a simple start/ready request with a done pulse and a parallel data_out.

Parameters:
- DATA_W, 32, frame length in bits (>=2).
- CLK_HALF, 8, sclk half-period in clk cycles (>=1); sclk period = 2*CLK_HALF clk.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  transfer request; accepted on a clk edge where start=1 and ready=1.
- ready  out  1  1 in IDLE; 0 otherwise.
- data_in  in  DATA_W  word to transmit; captured on acceptance.
- data_out  out  DATA_W  last received word; updated only when done pulses.
- done  out  1  one-cycle pulse at end of transfer.
- busy  out  1  equals ~ready.
- sclk  out  1  serial clock; idle low.
- ss  out  1  slave select, active low; idle high.
- mosi  out  1  serial data out.
- miso  in  1  serial data in; treated as synchronous to sclk phases.

Behaviour:
- Reset (async, any state): ss=1, sclk=0, mosi=0, ready=1, busy=0, done=0, data_out=0. FSM goes to IDLE, and the divider and bit counters clear. Reset mid-frame aborts the frame with no done pulse and data_out unchanged from 0.
- Divider: a counter 0..CLK_HALF-1 times every phase; each phase lasts exactly CLK_HALF clk cycles.
- Bit counter: counts 0..DATA_W-1.
- FSM states:
  - IDLE: ready=1, ss=1, sclk=0. On start&ready: load tx shift reg <= data_in, clear counters, go to SETUP. From the next cycle ss=0 and mosi=data_in[DATA_W-1].
  - SETUP (1 phase): sclk=0, ss=0. Then go to HIGH.
  - HIGH (1 phase): sclk=1. On the clk edge ending the phase, rx shift reg <= {rx[DATA_W-2:0], miso} and sclk -> 0.
    - If bit counter < DATA_W-1: go to LOW.
    - Else: go to HOLD.
  - LOW (1 phase): sclk=0. On entry, mosi <= next bit (tx shifted left) and the bit counter increments. At phase end go to HIGH.
  - HOLD (1 phase): sclk=0, ss=0, mosi holds the LSB. At phase end: ss <= 1, data_out <= rx, done <= 1 for one cycle, go to GAP.
  - GAP (1 phase): ss=1, ready=0. Guarantees ss high for at least CLK_HALF cycles between frames. Then go to IDLE.
- Timing from acceptance edge T:
  - ss low for (2*DATA_W+1)*CLK_HALF cycles.
  - done asserts T+(2*DATA_W+1)*CLK_HALF+1.
  - ready returns CLK_HALF cycles after done.
- Exactly DATA_W rising and DATA_W falling sclk edges per frame.
- mosi changes only while sclk=0 and at least CLK_HALF cycles before each rising edge.
- start while busy is ignored, with no queuing.
- start held high continuously gives back-to-back frames separated by the GAP phase.
- data_in changes after acceptance have no effect on the current frame.
- done and ready are never high in the same cycle.
- Outputs sclk, ss and mosi are driven directly from flops (glitch-free).

Test Plan:
- DATA_W=8, CLK_HALF=2, mosi looped to miso, data_in=0xA5, start 1 cycle -> ss low 34 cycles, 8 sclk rising edges, mosi bits 1,0,1,0,0,1,0,1, done 1 cycle, data_out=0xA5.
- miso tied 1, data_in=0x00 -> mosi constant 0, data_out=0xFF. Then miso tied 0 -> data_out=0x00.
- Pulse start at cycles 5, 10 and 20 of a frame -> no change to sclk/ss sequence, exactly one done, data_out from first frame only.
- start held high, data_in=0x3C then 0xC3, loopback -> two frames, ss high >=2 cycles between, data_out 0x3C then 0xC3.
- Assert rst at bit 4 of a frame -> same cycle ss=1, sclk=0, mosi=0. No done pulse. After release, a new 0x5A frame completes normally.
- Integration: DATA_W=32, CLK_HALF=8 driving spi_slave with 200 half-periods of traffic -> slave receives every word transmitted, no protocol violations.
